vinsn_dispatch_queue: RTL and testbench
=======================================

VINSN_DISPATCH_QUEUE -- requirements
Module: vinsn_dispatch_queue

Interface
REQ-001 SHALL have parameter Depth, default 4, meaning the number of instruction buffer entries (a power of two, 2 or more).
REQ-002 SHALL have parameter MaxInflight, default 4, meaning the number of issued-but-not-done instructions allowed at once (a power of two, 1 or more).
REQ-003 SHALL have one clock and an asynchronous active-low reset, with these ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
REQ-004 SHALL have these scalar-issue-side ports:
- valid_i  in  1  instruction offered.
- ready_o  out  1  instruction accepted.
- insn_i  in  32  instruction word.
- insn_id_i  in  insn_id_t  instruction ID.
- vec_context_i  in  vec_context_t  vector context.
REQ-005 SHALL have these vector-core-side ports:
- core_valid_o  out  1  instruction presented.
- core_ready_i  in  1  instruction taken.
- core_insn_o  out  32  instruction word.
- core_insn_id_o  out  insn_id_t  instruction ID.
- core_vec_context_o  out  vec_context_t  vector context.
REQ-006 SHALL have these completion and control ports:
- flush_i  in  1  drop buffered instructions.
- done_i  in  1  vector core completion.
- done_insn_id_i  in  insn_id_t  ID of the completed instruction.
REQ-007 SHALL have these status ports:
- inflight_cnt_o  out  $clog2(MaxInflight)+1  issued-not-done count.
- idle_o  out  1  buffer empty and nothing in flight.
- order_err_o  out  1  sticky completion-protocol error.

Function
REQ-008 SHALL hold each buffer entry as {insn, id, context} in a circular buffer with read/write pointers of $clog2(Depth) bits plus an occupancy counter of $clog2(Depth)+1 bits.
REQ-009 SHALL drive ready_o = (occupancy != Depth) && !flush_i; a push occurs when valid_i && ready_o.
REQ-010 SHALL NOT push through when full, even if a pop happens in the same cycle.
REQ-011 SHALL drive core_valid_o = (occupancy != 0) && (inflight < MaxInflight) && !flush_i; a pop occurs when core_valid_o && core_ready_i.
REQ-012 SHALL drive core_insn_o, core_insn_id_o and core_vec_context_o from the head entry, and SHALL hold them stable while core_valid_o is high and the pop has not occurred.
REQ-013 SHALL have no empty-buffer bypass: a pushed entry can be presented no earlier than the cycle after the push (minimum latency 1 cycle).
REQ-014 SHALL update occupancy as follows on each cycle:
- push only: +1.
- pop only: -1.
- push and pop: unchanged.
- pointers wrap modulo Depth.
REQ-015 SHALL, on a pop, push core_insn_id_o into an in-flight ID FIFO of MaxInflight entries and increment inflight.
REQ-016 SHALL, on done_i with inflight != 0, compare done_insn_id_i to the in-flight FIFO head, pop that head and decrement inflight; on a mismatch it SHALL set order_err_o and still pop.
REQ-017 SHALL leave inflight unchanged when a pop and a done occur in the same cycle, with both FIFO operations performed.
REQ-018 SHALL ignore done_i when inflight == 0, apart from setting order_err_o.
REQ-019 SHALL, on flush_i, reset the buffer pointers and occupancy to 0 on the next edge and discard all buffered entries.
REQ-020 SHALL leave inflight, the in-flight FIFO and order_err_o untouched by flush_i, and SHALL still process a done_i that arrives during the flush.
REQ-021 SHALL drive inflight_cnt_o as the registered inflight count.
REQ-022 SHALL drive idle_o = (occupancy == 0) && (inflight == 0).
REQ-023 SHALL keep order_err_o high once set, until reset.

Reset
REQ-024 SHALL, while rst_ni is low, asynchronously clear all pointers, occupancy, inflight and the in-flight FIFO pointers, and drive these outputs:
- ready_o = 1.
- core_valid_o = 0.
- inflight_cnt_o = 0.
- idle_o = 1.
- order_err_o = 0.
REQ-025 SHALL discard all buffered and in-flight state on a reset asserted mid-operation, with no output glitch after reset release.
REQ-026 SHALL NOT reset entry payload storage; the payload outputs are don't-care while core_valid_o = 0.

Verification
REQ-027 SHALL be covered by a bench running these directed scenarios:
- Fill: push IDs 1..4 with core_ready_i = 0 -> ready_o = 0 after the 4th push; then hold core_ready_i = 1 -> IDs 1,2,3,4 pop in order, one per cycle.
- In-flight limit: MaxInflight = 4, no done_i, 6 instructions pushed -> core_valid_o drops after 4 pops; one done_i with ID 1 -> the 5th pops next cycle, and inflight_cnt_o = 4.
- Simultaneous: pop and done in one cycle with inflight = 2 -> inflight_cnt_o stays 2 and order_err_o = 0.
- Flush: 3 buffered and 1 in flight, flush_i pulse -> occupancy 0 next cycle and inflight_cnt_o = 1; done_i with the matching ID -> idle_o = 1.
- Order error: in-flight IDs 5 and 6, done_i with ID 6 -> order_err_o = 1 and stays high; done_i with inflight = 0 -> order_err_o = 1.
- Reset mid-run: rst_ni low with a full buffer and inflight = 3 -> all outputs at reset values immediately, idle_o = 1.

Source files
------------

// File: rtl/vinsn_dispatch_queue.sv
// vinsn_dispatch_queue: buffers vector instructions from the scalar core and
// throttles issue to the vector core by tracking in-order in-flight IDs.
module vinsn_dispatch_queue #(
    parameter int  Depth         = 4,
    parameter int  MaxInflight   = 4,
    parameter type insn_id_t     = logic [7:0],
    parameter type vec_context_t = logic [15:0]
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [31:0]                    insn_i,
    input  insn_id_t                       insn_id_i,
    input  vec_context_t                   vec_context_i,
    output logic                           core_valid_o,
    input  logic                           core_ready_i,
    output logic [31:0]                    core_insn_o,
    output insn_id_t                       core_insn_id_o,
    output vec_context_t                   core_vec_context_o,
    input  logic                           flush_i,
    input  logic                           done_i,
    input  insn_id_t                       done_insn_id_i,
    output logic [$clog2(MaxInflight):0]   inflight_cnt_o,
    output logic                           idle_o,
    output logic                           order_err_o
);
    localparam int AW = $clog2(Depth);
    localparam int IW = MaxInflight > 1 ? $clog2(MaxInflight) : 1;
    localparam int CW = $clog2(MaxInflight) + 1;
    localparam logic [AW:0]   Full     = (AW+1)'(Depth);
    localparam logic [CW-1:0] MaxCnt   = CW'(MaxInflight);
    localparam logic [IW-1:0] LastSlot = IW'(MaxInflight - 1);

    logic [31:0]   insn_q [Depth];
    insn_id_t      id_q   [Depth];
    vec_context_t  ctx_q  [Depth];
    insn_id_t      fly_q  [MaxInflight];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   occ;
    logic [IW-1:0] fly_rd, fly_wr;
    logic [CW-1:0] inflight;
    logic          order_err;
    logic          push, pop, done_ok;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
        return p == LastSlot ? '0 : p + 1'b1;
    endfunction

    assign ready_o            = occ != Full && !flush_i;
    assign core_valid_o       = occ != '0 && inflight != MaxCnt && !flush_i;
    assign push               = valid_i && ready_o;
    assign pop                = core_valid_o && core_ready_i;
    assign done_ok            = done_i && inflight != '0;
    assign core_insn_o        = insn_q[rd_ptr];
    assign core_insn_id_o     = id_q[rd_ptr];
    assign core_vec_context_o = ctx_q[rd_ptr];
    assign inflight_cnt_o     = inflight;
    assign idle_o             = occ == '0 && inflight == '0;
    assign order_err_o        = order_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= (push && !pop) ? occ + 1'b1 : (pop && !push) ? occ - 1'b1 : occ;
        end
    end

    // Payload storage is intentionally unreset; it is only observed while valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            insn_q[wr_ptr] <= insn_i;
            id_q[wr_ptr]   <= insn_id_i;
            ctx_q[wr_ptr]  <= vec_context_i;
        end
        if (pop) fly_q[fly_wr] <= core_insn_id_o;
    end

    // Completions must arrive in issue order; any deviation latches order_err.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fly_rd    <= '0;
            fly_wr    <= '0;
            inflight  <= '0;
            order_err <= 1'b0;
        end else begin
            if (pop) fly_wr <= nxt(fly_wr);
            if (done_ok) fly_rd <= nxt(fly_rd);
            if (pop != done_ok) inflight <= pop ? inflight + 1'b1 : inflight - 1'b1;
            if (done_i && (!done_ok || done_insn_id_i != fly_q[fly_rd])) order_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vinsn_dispatch_queue.sv
// tb_vinsn_dispatch_queue: directed scenarios with hand-computed expectations
// for the vector instruction dispatch queue (Depth = MaxInflight = 4).
module tb_vinsn_dispatch_queue;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] insn_i;
    logic [7:0]  insn_id_i;
    logic [15:0] vec_context_i;
    logic        core_valid_o;
    logic        core_ready_i;
    logic [31:0] core_insn_o;
    logic [7:0]  core_insn_id_o;
    logic [15:0] core_vec_context_o;
    logic        flush_i;
    logic        done_i;
    logic [7:0]  done_insn_id_i;
    logic [2:0]  inflight_cnt_o;
    logic        idle_o;
    logic        order_err_o;
    int          total  = 0;
    int          passed = 0;

    vinsn_dispatch_queue dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(valid_i), .ready_o(ready_o), .insn_i(insn_i),
        .insn_id_i(insn_id_i), .vec_context_i(vec_context_i),
        .core_valid_o(core_valid_o), .core_ready_i(core_ready_i),
        .core_insn_o(core_insn_o), .core_insn_id_o(core_insn_id_o),
        .core_vec_context_o(core_vec_context_o),
        .flush_i(flush_i), .done_i(done_i), .done_insn_id_i(done_insn_id_i),
        .inflight_cnt_o(inflight_cnt_o), .idle_o(idle_o), .order_err_o(order_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [7:0] id);
        valid_i       = 1'b1;
        insn_id_i     = id;
        insn_i        = 32'hA000_0000 | {24'd0, id};
        vec_context_i = 16'hC000 | {8'd0, id};
    endtask

    task automatic push_n(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            offer(first + 8'(i));
            tick();
        end
        valid_i = 1'b0;
    endtask

    task automatic done_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            done_i         = 1'b1;
            done_insn_id_i = first + 8'(i);
            tick();
        end
        done_i = 1'b0;
    endtask

    task automatic pop_cycles(input int n);
        core_ready_i = 1'b1;
        repeat (n) tick();
        core_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        total++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready_o); else passed++;
        total++; if (core_valid_o !== 1'b0) $display("FAIL reset_core_valid: got %b expected 0", core_valid_o); else passed++;
        total++; if (inflight_cnt_o !== 3'd0) $display("FAIL reset_inflight: got %0d expected 0", inflight_cnt_o); else passed++;
        total++; if (idle_o !== 1'b1) $display("FAIL reset_idle: got %b expected 1", idle_o); else passed++;
        total++; if (order_err_o !== 1'b0) $display("FAIL reset_order_err: got %b expected 0", order_err_o); else passed++;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        core_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            offer(8'(i));
            #1;
            total++; if (ready_o !== 1'b1) $display("FAIL fill_ready_%0d: got %b expected 1", i, ready_o); else passed++;
            tick();
        end
        valid_i = 1'b0;
        #1;
        total++; if (ready_o !== 1'b0) $display("FAIL fill_full_ready: got %b expected 0", ready_o); else passed++;
        core_ready_i = 1'b1;
        #1;
        for (int i = 1; i <= 4; i++) begin
            total++; if (core_valid_o !== 1'b1 || core_insn_id_o !== 8'(i))
                $display("FAIL fill_pop_%0d: got valid %b id %0d expected valid 1 id %0d", i, core_valid_o, core_insn_id_o, i); else passed++;
            total++; if (core_insn_o !== (32'hA000_0000 | i) || core_vec_context_o !== (16'hC000 | 16'(i)))
                $display("FAIL fill_payload_%0d: got %h/%h expected %h/%h", i, core_insn_o, core_vec_context_o, 32'hA000_0000 | i, 16'hC000 | 16'(i)); else passed++;
            tick();
        end
        core_ready_i = 1'b0;
        total++; if (core_valid_o !== 1'b0 || inflight_cnt_o !== 3'd4)
            $display("FAIL fill_drained: got valid %b inflight %0d expected valid 0 inflight 4", core_valid_o, inflight_cnt_o); else passed++;
        done_seq(8'd1, 4);
        total++; if (idle_o !== 1'b1 || order_err_o !== 1'b0)
            $display("FAIL fill_idle: got idle %b err %b expected idle 1 err 0", idle_o, order_err_o); else passed++;
    endtask

    task automatic test_inflight_limit();
        core_ready_i = 1'b1;
        push_n(8'd11, 6);
        total++; if (core_valid_o !== 1'b0 || inflight_cnt_o !== 3'd4)
            $display("FAIL limit_stall: got valid %b inflight %0d expected valid 0 inflight 4", core_valid_o, inflight_cnt_o); else passed++;
        total++; if (core_insn_id_o !== 8'd15) $display("FAIL limit_head: got %0d expected 15", core_insn_id_o); else passed++;
        done_i = 1'b1;
        done_insn_id_i = 8'd11;
        tick();
        done_i = 1'b0;
        total++; if (core_valid_o !== 1'b1 || core_insn_id_o !== 8'd15)
            $display("FAIL limit_release: got valid %b id %0d expected valid 1 id 15", core_valid_o, core_insn_id_o); else passed++;
        tick();
        total++; if (inflight_cnt_o !== 3'd4 || core_valid_o !== 1'b0)
            $display("FAIL limit_refill: got inflight %0d valid %b expected inflight 4 valid 0", inflight_cnt_o, core_valid_o); else passed++;
        done_seq(8'd12, 5);
        core_ready_i = 1'b0;
        total++; if (idle_o !== 1'b1 || order_err_o !== 1'b0)
            $display("FAIL limit_idle: got idle %b err %b expected idle 1 err 0", idle_o, order_err_o); else passed++;
    endtask

    task automatic test_simultaneous();
        core_ready_i = 1'b0;
        push_n(8'd21, 3);
        pop_cycles(2);
        total++; if (inflight_cnt_o !== 3'd2) $display("FAIL simul_pre: got %0d expected 2", inflight_cnt_o); else passed++;
        core_ready_i = 1'b1;
        done_i = 1'b1;
        done_insn_id_i = 8'd21;
        tick();
        core_ready_i = 1'b0;
        done_i = 1'b0;
        total++; if (inflight_cnt_o !== 3'd2) $display("FAIL simul_inflight: got %0d expected 2", inflight_cnt_o); else passed++;
        total++; if (order_err_o !== 1'b0) $display("FAIL simul_err: got %b expected 0", order_err_o); else passed++;
        total++; if (core_valid_o !== 1'b0) $display("FAIL simul_empty: got %b expected 0", core_valid_o); else passed++;
        done_seq(8'd22, 2);
        total++; if (idle_o !== 1'b1 || order_err_o !== 1'b0)
            $display("FAIL simul_idle: got idle %b err %b expected idle 1 err 0", idle_o, order_err_o); else passed++;
    endtask

    task automatic test_flush();
        core_ready_i = 1'b0;
        push_n(8'd31, 4);
        pop_cycles(1);
        flush_i = 1'b1;
        #1;
        total++; if (ready_o !== 1'b0 || core_valid_o !== 1'b0)
            $display("FAIL flush_during: got ready %b valid %b expected 0 0", ready_o, core_valid_o); else passed++;
        tick();
        flush_i = 1'b0;
        #1;
        total++; if (core_valid_o !== 1'b0 || ready_o !== 1'b1)
            $display("FAIL flush_empty: got valid %b ready %b expected 0 1", core_valid_o, ready_o); else passed++;
        total++; if (inflight_cnt_o !== 3'd1 || idle_o !== 1'b0)
            $display("FAIL flush_inflight: got inflight %0d idle %b expected 1 0", inflight_cnt_o, idle_o); else passed++;
        done_seq(8'd31, 1);
        total++; if (idle_o !== 1'b1 || order_err_o !== 1'b0)
            $display("FAIL flush_idle: got idle %b err %b expected 1 0", idle_o, order_err_o); else passed++;
    endtask

    task automatic test_order_error();
        core_ready_i = 1'b0;
        push_n(8'd5, 2);
        pop_cycles(2);
        done_seq(8'd6, 1);
        total++; if (order_err_o !== 1'b1 || inflight_cnt_o !== 3'd1)
            $display("FAIL order_mismatch: got err %b inflight %0d expected 1 1", order_err_o, inflight_cnt_o); else passed++;
        done_seq(8'd6, 1);
        total++; if (order_err_o !== 1'b1 || inflight_cnt_o !== 3'd0)
            $display("FAIL order_sticky: got err %b inflight %0d expected 1 0", order_err_o, inflight_cnt_o); else passed++;
        do_reset();
        done_seq(8'd9, 1);
        total++; if (order_err_o !== 1'b1 || inflight_cnt_o !== 3'd0)
            $display("FAIL order_spurious: got err %b inflight %0d expected 1 0", order_err_o, inflight_cnt_o); else passed++;
        do_reset();
    endtask

    task automatic test_reset_mid_run();
        core_ready_i = 1'b0;
        push_n(8'd41, 3);
        pop_cycles(3);
        push_n(8'd44, 4);
        total++; if (ready_o !== 1'b0 || inflight_cnt_o !== 3'd3)
            $display("FAIL midrst_pre: got ready %b inflight %0d expected 0 3", ready_o, inflight_cnt_o); else passed++;
        rst_ni = 1'b0;
        #1;
        total++; if (ready_o !== 1'b1 || core_valid_o !== 1'b0)
            $display("FAIL midrst_handshake: got ready %b valid %b expected 1 0", ready_o, core_valid_o); else passed++;
        total++; if (inflight_cnt_o !== 3'd0 || idle_o !== 1'b1 || order_err_o !== 1'b0)
            $display("FAIL midrst_status: got inflight %0d idle %b err %b expected 0 1 0", inflight_cnt_o, idle_o, order_err_o); else passed++;
        tick();
        rst_ni = 1'b1;
        tick();
        total++; if (core_valid_o !== 1'b0 || idle_o !== 1'b1 || ready_o !== 1'b1)
            $display("FAIL midrst_release: got valid %b idle %b ready %b expected 0 1 1", core_valid_o, idle_o, ready_o); else passed++;
    endtask

    initial begin
        valid_i        = 1'b0;
        insn_i         = '0;
        insn_id_i      = '0;
        vec_context_i  = '0;
        core_ready_i   = 1'b0;
        flush_i        = 1'b0;
        done_i         = 1'b0;
        done_insn_id_i = '0;
        test_reset();
        test_fill();
        test_inflight_limit();
        test_simultaneous();
        test_flush();
        test_order_error();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
